// File: rtl/popcount_pkg.sv
// popcount_pkg
//   Shared types and constants for the popcount sequencer slice.
//   - state_t  : sequencer FSM states, 2-bit encoding
//   - NIBBLE_W : width of the slice handed to the ones-count unit each cycle
//   - ONES_W   : width of a single nibble's ones count (0..4 needs 3 bits)
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;
    localparam int ONES_W   = 3;

endpackage : popcount_pkg

// File: rtl/nibble_ones_count.sv
// nibble_ones_count
//   Purely combinational ones counter for one 4-bit nibble.
//   Ports:
//     nibble : in  [NIBBLE_W-1:0]  nibble to be counted
//     ones   : out [ONES_W-1:0]    number of set bits in nibble (0..4)
module nibble_ones_count
    import popcount_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [ONES_W-1:0]   ones
);

    // Each bit is zero-extended before summing so the adder is ONES_W wide.
    always_comb begin
        ones = ONES_W'(nibble[0]) + ONES_W'(nibble[1])
             + ONES_W'(nibble[2]) + ONES_W'(nibble[3]);
    end

endmodule : nibble_ones_count

// File: rtl/popcount_sequencer.sv
// popcount_sequencer
//   Computes the population count of a WIDTH-bit word by walking it one nibble
//   per cycle (LSB nibble first) through a single shared nibble ones-counter,
//   accumulating the partial counts. Requester handshake is start/busy/done.
//
//   Parameters:
//     WIDTH : operand width, multiple of 4, 4..64
//     CW    : result width, $clog2(WIDTH+1) (derived)
//   Ports:
//     clk     : in   clock, all state updates on posedge
//     rst     : in   synchronous active-low reset
//     start   : in   job request, honoured only when not busy
//     data_in : in   [WIDTH-1:0] operand, captured when start is accepted
//     busy    : out  high while nibbles are being processed
//     done    : out  one-cycle pulse, count is valid from this cycle on
//     count   : out  [CW-1:0] ones in the last completed operand, held
//
//   Build option:
//     ZERO_SKIP_EN : when defined, a job finishes early as soon as the
//                    remaining (already shifted) operand bits are all zero.
module popcount_sequencer
    import popcount_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   shreg_q,  shreg_d;
    logic [CW-1:0]      acc_q,    acc_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [CW-1:0]      count_q,  count_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [ONES_W-1:0]  nib_ones;
    logic [CW-1:0]      acc_sum;
    logic [WIDTH-1:0]   shreg_shift;
    logic               last_nib;
    logic               finish;

    // The single shared ones-count unit always looks at the low nibble.
    nibble_ones_count u_nibble_ones_count (
        .nibble (shreg_q[NIBBLE_W-1:0]),
        .ones   (nib_ones)
    );

    // Next-state logic. busy/done are computed for the state being entered so
    // that the registered outputs line up with the registered state.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        count_d     = count_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        acc_sum     = acc_q + CW'(nib_ones);
        shreg_shift = shreg_q >> NIBBLE_W;
        last_nib    = (idx_q == IDX_W'(NIB - 1));
`ifdef ZERO_SKIP_EN
        finish      = last_nib || (shreg_shift == '0);
`else
        finish      = last_nib;
`endif

        case (state_q)
            // DONE accepts a new job exactly like IDLE so jobs can run
            // back-to-back without an idle bubble.
            IDLE, DONE: begin
                if (start) begin
                    shreg_d = data_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = acc_sum;
                shreg_d = shreg_shift;
                idx_d   = idx_q + IDX_W'(1);
                if (finish) begin
                    state_d = DONE;
                    count_d = acc_sum;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset also aborts any job in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule : popcount_sequencer

// File: tb/tb_popcount_sequencer.sv
// tb_popcount_sequencer
//   Directed, table-driven bench for popcount_sequencer (WIDTH=16).
//   Expected latencies follow the ZERO_SKIP_EN build option.
module tb_popcount_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

`ifdef ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        int          exp_count;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[9];

    popcount_sequencer #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] d);
        start   = s;
        data_in = d;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present a job for exactly one accepting edge, then drop start.
    task automatic startJob(input logic [15:0] d);
        applyStimulus(1'b1, d);
        step();
        applyStimulus(1'b0, 16'h0000);
    endtask

    // Called while sampling cycle first_cyc after the accepting edge; waits
    // for done and checks latency, result and number of busy cycles seen.
    task automatic waitDone(input string name, input int first_cyc,
                            input int exp_lat, input int exp_count);
        int cyc    = first_cyc;
        int busy_n = 0;
        bit seen   = 1'b0;
        while (cyc <= 40) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_n++;
            step();
            cyc++;
        end
        if (!seen) begin
            checkOutput({name, " done timeout"}, 0, 1);
            return;
        end
        checkOutput({name, " latency"}, cyc, exp_lat);
        checkOutput({name, " count"}, int'(count), exp_count);
        checkOutput({name, " busy cycles"}, busy_n, exp_lat - first_cyc);
        checkOutput({name, " busy in done"}, int'(busy), 0);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000);

        vecs[0] = '{16'hFFFF, 16, 5,               "ffff"};
        vecs[1] = '{16'h8421,  4, 5,               "8421"};
        vecs[2] = '{16'h0000,  0, ZSKIP ? 2 : 5,   "0000"};
        vecs[3] = '{16'h000F,  4, ZSKIP ? 2 : 5,   "000f"};
        vecs[4] = '{16'h0001,  1, ZSKIP ? 2 : 5,   "0001"};
        vecs[5] = '{16'h1234,  5, 5,               "1234"};
        vecs[6] = '{16'hF000,  4, 5,               "f000"};
        vecs[7] = '{16'h00F0,  4, ZSKIP ? 3 : 5,   "00f0"};
        vecs[8] = '{16'h0F0F,  8, ZSKIP ? 4 : 5,   "0f0f"};

        // Reset held two cycles with start asserted must keep everything quiet.
        applyStimulus(1'b1, 16'hFFFF);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("reset busy", int'(busy), 0);
            checkOutput("reset done", int'(done), 0);
            checkOutput("reset count", int'(count), 0);
        end
        applyStimulus(1'b0, 16'h0000);
        rst = 1'b1;
        step();
        checkOutput("idle after reset busy", int'(busy), 0);

        // Table of single jobs, each followed by a check that done is a pulse
        // and that count holds once the job is over.
        for (int v = 0; v < 9; v++) begin
            startJob(vecs[v].data);
            waitDone(vecs[v].name, 1, vecs[v].exp_lat, vecs[v].exp_count);
            step();
            checkOutput({vecs[v].name, " done pulse"}, int'(done), 0);
            step();
            checkOutput({vecs[v].name, " count held"}, int'(count), vecs[v].exp_count);
        end

        // start while busy is ignored and data_in is not recaptured.
        startJob(16'h0001);
        checkOutput("ignore busy at cycle1", int'(busy), 1);
        applyStimulus(1'b1, 16'h00FF);
        step();
        applyStimulus(1'b0, 16'h0000);
        waitDone("ignore", 2, ZSKIP ? 2 : 5, 1);
        step();
        checkOutput("ignore no relaunch busy", int'(busy), 0);
        checkOutput("ignore no relaunch done", int'(done), 0);

        // start held during DONE launches the next job back-to-back.
        startJob(16'h0001);
        waitDone("b2b first", 1, ZSKIP ? 2 : 5, 1);
        startJob(16'h0F0F);
        waitDone("b2b second", 1, ZSKIP ? 4 : 5, 8);
        step();

        // Reset on the second RUN cycle aborts the job without a done pulse.
        startJob(16'hFFFF);
        step();
        checkOutput("abort busy before reset", int'(busy), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort count", int'(count), 0);
        begin
            int done_seen = 0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (done === 1'b1) done_seen++;
            end
            checkOutput("abort no done pulse", done_seen, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_popcount_sequencer
